logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit for the ALUOP group.
- Generalises the fixed 32-bit inverter: configurable width, selectable operation (NOT plus seven two-operand functions), configurable register depth.
- Valid/ready handshake on both sides so the execute stage can stall it.
- Also produces a zero flag for branch/compare use.

---
 rtl/logic_unit_pipe_if.sv | 25 ++
 rtl/logic_unit_pipe.sv | 80 ++++++++
 tb/tb_logic_unit_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The master drives operands and consumes results; the slave is the unit itself.
interface logic_unit_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit (NOT plus seven two-operand ops) with a zero flag.
// The whole pipe advances in lock-step; a stall at the output freezes every stage.
module logic_unit_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    logic_unit_pipe_if.slave bus_io
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("logic_unit_pipe: WIDTH must be in 1..64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("logic_unit_pipe: STAGES must be in 1..4");
    end

    logic [WIDTH-1:0]  res;
    logic              res_zero;
    logic              advance;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] zero_q,  zero_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];

    always_comb begin
        res = '0;
        case (bus_io.in_op)
            3'b000: res = ~bus_io.in_a;
            3'b001: res = bus_io.in_a & bus_io.in_b;
            3'b010: res = bus_io.in_a | bus_io.in_b;
            3'b011: res = bus_io.in_a ^ bus_io.in_b;
            3'b100: res = ~(bus_io.in_a & bus_io.in_b);
            3'b101: res = ~(bus_io.in_a | bus_io.in_b);
            3'b110: res = ~(bus_io.in_a ^ bus_io.in_b);
            3'b111: res = bus_io.in_a & ~bus_io.in_b;
            default: res = '0;
        endcase
        res_zero = (res == '0);
    end

    // Free to advance whenever the last stage is empty or being consumed.
    assign advance = bus_io.out_ready | ~valid_q[STAGES-1];

    always_comb begin
        valid_d = valid_q;
        zero_d  = zero_q;
        data_d  = data_q;
        if (advance) begin
            valid_d[0] = bus_io.in_valid;
            zero_d[0]  = res_zero;
            data_d[0]  = res;
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                zero_d[i]  = zero_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            zero_q  <= '0;
            data_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            zero_q  <= zero_d;
            data_q  <= data_d;
        end
    end

    assign bus_io.in_ready  = advance;
    assign bus_io.out_valid = valid_q[STAGES-1];
    assign bus_io.out_data  = data_q[STAGES-1];
    assign bus_io.out_zero  = zero_q[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: scoreboard on a 32/2 instance plus
// latency/value checks on 8/1 and 64/4 instances.
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(32)) bus32 ();
    logic_unit_pipe_if #(.WIDTH(8))  bus8  ();
    logic_unit_pipe_if #(.WIDTH(64)) bus64 ();

    logic_unit_pipe #(.WIDTH(32), .STAGES(2)) u_dut32 (.clk(clk), .rst(rst), .bus_io(bus32));
    logic_unit_pipe #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk(clk), .rst(rst), .bus_io(bus8));
    logic_unit_pipe #(.WIDTH(64), .STAGES(4)) u_dut64 (.clk(clk), .rst(rst), .bus_io(bus64));

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        zero;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Truth-table model: tt[{a,b}] gives the result bit.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [3:0]  tt;
        logic [31:0] r;
        case (op)
            3'd0: tt = 4'b0011;
            3'd1: tt = 4'b1000;
            3'd2: tt = 4'b1110;
            3'd3: tt = 4'b0110;
            3'd4: tt = 4'b0111;
            3'd5: tt = 4'b0001;
            3'd6: tt = 4'b1001;
            default: tt = 4'b0100;
        endcase
        for (int i = 0; i < 32; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.zero = (d == 32'h0);
        return e;
    endfunction

    // Output side of the scoreboard: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus32.out_valid && bus32.out_ready) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_out: observed 0x%0h, expected no output", bus32.out_data);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", {32'h0, bus32.out_data}, {32'h0, e.data});
                check("out_zero", {63'h0, bus32.out_zero}, {63'h0, e.zero});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        int n = 0;
        bus32.in_valid = 1'b1;
        bus32.in_op    = op;
        bus32.in_a     = a;
        bus32.in_b     = b;
        @(negedge clk);
        while (!bus32.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", {63'h0, bus32.in_ready}, 64'h1);
        if (bus32.in_ready) sb.push_back(mk_exp(exp));
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk);
        #1;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'h0);
    endtask

    logic [31:0] ops_exp [8];
    logic [31:0] bp_a [4];
    logic [31:0] bp_b [4];
    int          lat;

    initial begin
        ops_exp = '{32'h0F0F0F0F, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                    32'h0FFF0FFF, 32'h000F000F, 32'hF00FF00F, 32'h00F000F0};
        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_op = '0; bus32.in_a = '0; bus32.in_b = '0;
        bus32.out_ready = 1'b1;
        bus8.in_valid  = 1'b0; bus8.in_op  = '0; bus8.in_a  = '0; bus8.in_b  = '0;
        bus8.out_ready  = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_op = '0; bus64.in_a = '0; bus64.in_b = '0;
        bus64.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", {63'h0, bus32.out_valid}, 64'h0);
        check("rst_out_data",  {32'h0, bus32.out_data},  64'h0);
        check("rst_out_zero",  {63'h0, bus32.out_zero},  64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rel_in_ready", {63'h0, bus32.in_ready}, 64'h1);

        // Basic NOT with latency
        bus32.in_valid = 1'b1; bus32.in_op = 3'b000; bus32.in_a = 32'h0000FFFF; bus32.in_b = '0;
        sb.push_back(mk_exp(32'hFFFF0000));
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        lat = 1;
        while (!bus32.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("not_latency", 64'(lat), 64'd2);
        check("not_data", {32'h0, bus32.out_data}, 64'hFFFF0000);
        check("not_zero", {63'h0, bus32.out_zero}, 64'h0);
        drain();

        // All eight ops back-to-back
        for (int i = 0; i < 8; i++) send(3'(i), 32'hF0F0F0F0, 32'hFF00FF00, ops_exp[i]);
        drain();

        // Zero flag
        send(3'b011, 32'hDEADBEEF, 32'hDEADBEEF, model(3'b011, 32'hDEADBEEF, 32'hDEADBEEF));
        send(3'b000, 32'hFFFFFFFF, 32'h0, model(3'b000, 32'hFFFFFFFF, 32'h0));
        drain();

        // Backpressure: 4 XORs with a 3-cycle stall once output is valid
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 32'h12345678 + 32'(i) * 32'h01010101;
            bp_b[i] = 32'h0F0F0F0F << i;
        end
        send(3'b011, bp_a[0], bp_b[0], model(3'b011, bp_a[0], bp_b[0]));
        send(3'b011, bp_a[1], bp_b[1], model(3'b011, bp_a[1], bp_b[1]));
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1; bus32.in_op = 3'b011; bus32.in_a = bp_a[2]; bus32.in_b = bp_b[2];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", {63'h0, bus32.in_ready}, 64'h0);
            check("stall_valid", {63'h0, bus32.out_valid}, 64'h1);
            check("stall_data", {32'h0, bus32.out_data}, {32'h0, sb[0].data});
        end
        @(posedge clk);
        #1;
        bus32.out_ready = 1'b1;
        bus32.in_valid  = 1'b0;
        send(3'b011, bp_a[2], bp_b[2], model(3'b011, bp_a[2], bp_b[2]));
        send(3'b011, bp_a[3], bp_b[3], model(3'b011, bp_a[3], bp_b[3]));
        drain();

        // Reset mid-stream with two results in flight
        bus32.out_ready = 1'b0;
        send(3'b001, 32'hA5A5A5A5, 32'hFFFF0000, 32'hA5A50000);
        send(3'b010, 32'h0000000F, 32'h000000F0, 32'h000000FF);
        check("inflight_valid", {63'h0, bus32.out_valid}, 64'h1);
        rst = 1'b1;
        #1;
        check("midrst_valid", {63'h0, bus32.out_valid}, 64'h0);
        check("midrst_data",  {32'h0, bus32.out_data},  64'h0);
        check("midrst_zero",  {63'h0, bus32.out_zero},  64'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", {63'h0, bus32.in_ready}, 64'h1);
        bus32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_stays_empty", {63'h0, bus32.out_valid}, 64'h0);

        // WIDTH=8, STAGES=1
        bus8.in_valid = 1'b1; bus8.in_op = 3'b000; bus8.in_a = 8'h5A;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w8_latency", 64'(lat), 64'd1);
        check("w8_data", {56'h0, bus8.out_data}, 64'hA5);
        check("w8_zero", {63'h0, bus8.out_zero}, 64'h0);

        // WIDTH=64, STAGES=4
        bus64.in_valid = 1'b1; bus64.in_op = 3'b000; bus64.in_a = 64'h0123456789ABCDEF;
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        lat = 1;
        while (!bus64.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w64_latency", 64'(lat), 64'd4);
        check("w64_data", bus64.out_data, 64'hFEDCBA9876543210);
        check("w64_zero", {63'h0, bus64.out_zero}, 64'h0);
        @(posedge clk);
        #1;
        check("w64_single", {63'h0, bus64.out_valid}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
